// File: rtl/display_source_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : display_source_scheduler
// Purpose  : Time-shares one seven-segment display between several counter
//            sources, with a blanking gap on every source switch.
// Revision : 1.0 - initial release
// ============================================================================
module display_source_scheduler #(
    parameter  int NUM_SRC        = 4,
    parameter  int NUM_SEGMENTS   = 4,
    parameter  int DWELL_CYCLES   = 200000000,
    parameter  int BLANK_CYCLES   = 5000000,
    parameter  int FOLLOW_UPDATES = 1,
    localparam int SEL_W          = $clog2(NUM_SRC)
) (
    input  logic                                      clk,
    input  logic                                      CPU_RESETN,
    input  logic [NUM_SRC-1:0][NUM_SEGMENTS-1:0][3:0] src_encoded,
    input  logic [NUM_SRC-1:0][NUM_SEGMENTS-1:0]      src_digit_point,
    input  logic [NUM_SRC-1:0]                        src_update,
    input  logic                                      auto_en,
    input  logic                                      next_src,
    output logic [NUM_SEGMENTS-1:0][3:0]              encoded,
    output logic [NUM_SEGMENTS-1:0]                   digit_point,
    output logic                                      blank,
    output logic [SEL_W-1:0]                          sel,
    output logic [NUM_SRC-1:0]                        sel_onehot
);

    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam int BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [DWELL_W-1:0] c_DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [BLANK_W-1:0] c_BLANK_LAST =
        BLANK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [0:0] {
        ST_SHOW  = 1'b0,
        ST_BLANK = 1'b1
    } state_t;

    state_t                             r_state, w_state_nxt;
    logic [SEL_W-1:0]                   r_sel, w_sel_nxt;
    logic [SEL_W-1:0]                   r_pending, w_pending_nxt;
    logic [DWELL_W-1:0]                 r_dwell_cnt, w_dwell_nxt;
    logic [BLANK_W-1:0]                 r_blank_cnt, w_blank_cnt_nxt;
    logic [NUM_SRC-1:0]                 r_sel_onehot, w_onehot_nxt;
    logic [NUM_SEGMENTS-1:0][3:0]       r_encoded;
    logic [NUM_SEGMENTS-1:0]            r_digit_point;
    logic                               r_blank;
    logic                               w_follow_hit;
    logic [SEL_W-1:0]                   w_follow_tgt;
    logic                               w_trigger;
    logic [SEL_W-1:0]                   w_target;
    logic [SEL_W-1:0]                   w_pending_inc;

    function automatic logic [SEL_W-1:0] f_wrap_inc(input logic [SEL_W-1:0] v);
        return (v == SEL_W'(NUM_SRC - 1)) ? '0 : v + 1'b1;
    endfunction

    // Round-robin search from sel+1; descending k so the nearest requester wins.
    always_comb begin
        w_follow_hit = 1'b0;
        w_follow_tgt = r_sel;
        if (FOLLOW_UPDATES != 0) begin
            for (int k = NUM_SRC - 1; k >= 1; k--) begin
                logic [SEL_W-1:0] w_idx;
                w_idx = SEL_W'((int'(r_sel) + k) % NUM_SRC);
                if (src_update[w_idx]) begin
                    w_follow_hit = 1'b1;
                    w_follow_tgt = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_pending_nxt   = r_pending;
        w_dwell_nxt     = '0;
        w_blank_cnt_nxt = r_blank_cnt;
        w_trigger       = 1'b0;
        w_target        = r_sel;
        w_pending_inc   = next_src ? f_wrap_inc(r_pending) : r_pending;
        case (r_state)
            ST_SHOW: begin
                if (next_src) begin
                    w_trigger = 1'b1;
                    w_target  = f_wrap_inc(r_sel);
                end else if (w_follow_hit) begin
                    w_trigger = 1'b1;
                    w_target  = w_follow_tgt;
                end else if (auto_en && (r_dwell_cnt == c_DWELL_LAST)) begin
                    w_trigger = 1'b1;
                    w_target  = f_wrap_inc(r_sel);
                end
                if (w_trigger) begin
                    if (BLANK_CYCLES == 0) begin
                        w_sel_nxt = w_target;
                    end else begin
                        w_pending_nxt   = w_target;
                        w_blank_cnt_nxt = '0;
                        w_state_nxt     = ST_BLANK;
                    end
                end else if (auto_en && !src_update[r_sel]) begin
                    w_dwell_nxt = r_dwell_cnt + 1'b1;
                end
            end
            ST_BLANK: begin
                w_pending_nxt = w_pending_inc;
                if (r_blank_cnt == c_BLANK_LAST) begin
                    w_sel_nxt       = w_pending_inc;
                    w_blank_cnt_nxt = '0;
                    w_state_nxt     = ST_SHOW;
                end else begin
                    w_blank_cnt_nxt = r_blank_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_SHOW;
        endcase
        w_onehot_nxt            = '0;
        w_onehot_nxt[w_sel_nxt] = 1'b1;
    end

    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state       <= ST_SHOW;
            r_sel         <= '0;
            r_pending     <= '0;
            r_dwell_cnt   <= '0;
            r_blank_cnt   <= '0;
            r_sel_onehot  <= NUM_SRC'(1);
            r_encoded     <= '0;
            r_digit_point <= '0;
            r_blank       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_pending     <= w_pending_nxt;
            r_dwell_cnt   <= w_dwell_nxt;
            r_blank_cnt   <= w_blank_cnt_nxt;
            r_sel_onehot  <= w_onehot_nxt;
            r_encoded     <= (r_state == ST_SHOW) ? src_encoded[r_sel] : '0;
            r_digit_point <= (r_state == ST_SHOW) ? src_digit_point[r_sel] : '0;
            r_blank       <= (r_state == ST_BLANK);
        end
    end

    assign encoded     = r_encoded;
    assign digit_point = r_digit_point;
    assign blank       = r_blank;
    assign sel         = r_sel;
    assign sel_onehot  = r_sel_onehot;

endmodule
`default_nettype wire

// File: tb/tb_display_source_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_source_scheduler
// Purpose  : Randomized scoreboard bench for display_source_scheduler, running a
//            blanking/follow instance and a no-gap/no-follow instance in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_source_scheduler;

    localparam int N     = 4;
    localparam int DWELL = 20;

    typedef struct packed {
        logic [3:0][3:0] enc;
        logic [3:0]      dp;
        logic            blank;
        logic [1:0]      sel;
        logic [3:0]      oh;
    } exp_t;

    localparam exp_t c_RESET_EXP = '{enc: '0, dp: '0, blank: 1'b0, sel: 2'd0, oh: 4'b0001};

    logic                 clk = 1'b0;
    logic                 CPU_RESETN;
    logic [3:0][3:0][3:0] src_encoded;
    logic [3:0][3:0]      src_digit_point;
    logic [3:0]           src_update;
    logic                 auto_en;
    logic                 next_src;

    logic [3:0][3:0] encoded0, encoded1;
    logic [3:0]      digit_point0, digit_point1;
    logic            blank0, blank1;
    logic [1:0]      sel0, sel1;
    logic [3:0]      sel_onehot0, sel_onehot1;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state: instance 0 has a 3-cycle gap and follow mode,
    // instance 1 switches with no gap and ignores other sources' updates.
    int         p_blank[2]  = '{3, 0};
    int         p_follow[2] = '{1, 0};
    logic       m_showing[2];
    logic [1:0] m_sel[2];
    logic [1:0] m_pending[2];
    int         m_dwell[2];
    int         m_left[2];

    always #5 clk = ~clk;

    display_source_scheduler #(
        .NUM_SRC(N), .NUM_SEGMENTS(4), .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(3), .FOLLOW_UPDATES(1)
    ) u_dut0 (
        .clk(clk), .CPU_RESETN(CPU_RESETN),
        .src_encoded(src_encoded), .src_digit_point(src_digit_point),
        .src_update(src_update), .auto_en(auto_en), .next_src(next_src),
        .encoded(encoded0), .digit_point(digit_point0), .blank(blank0),
        .sel(sel0), .sel_onehot(sel_onehot0)
    );

    display_source_scheduler #(
        .NUM_SRC(N), .NUM_SEGMENTS(4), .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(0), .FOLLOW_UPDATES(0)
    ) u_dut1 (
        .clk(clk), .CPU_RESETN(CPU_RESETN),
        .src_encoded(src_encoded), .src_digit_point(src_digit_point),
        .src_update(src_update), .auto_en(auto_en), .next_src(next_src),
        .encoded(encoded1), .digit_point(digit_point1), .blank(blank1),
        .sel(sel1), .sel_onehot(sel_onehot1)
    );

    task automatic model_reset(input int m);
        m_showing[m] = 1'b1;
        m_sel[m]     = 2'd0;
        m_pending[m] = 2'd0;
        m_dwell[m]   = 0;
        m_left[m]    = 0;
    endtask

    task automatic model_step(input int m, output exp_t e);
        int         tgt;
        logic [3:0] others;
        logic [1:0] idx;
        if (!CPU_RESETN) begin
            model_reset(m);
            e = c_RESET_EXP;
            return;
        end
        e.enc   = m_showing[m] ? src_encoded[m_sel[m]] : '0;
        e.dp    = m_showing[m] ? src_digit_point[m_sel[m]] : '0;
        e.blank = !m_showing[m];
        if (m_showing[m]) begin
            tgt    = -1;
            others = src_update & ~(4'b0001 << m_sel[m]);
            if (next_src) begin
                tgt = (int'(m_sel[m]) + 1) % N;
            end else if (p_follow[m] != 0 && others != 4'b0000) begin
                for (int k = 1; k < N; k++) begin
                    idx = 2'((int'(m_sel[m]) + k) % N);
                    if (tgt < 0 && others[idx]) tgt = int'(idx);
                end
            end else if (auto_en && m_dwell[m] == DWELL - 1) begin
                tgt = (int'(m_sel[m]) + 1) % N;
            end
            if (tgt >= 0) begin
                m_dwell[m] = 0;
                if (p_blank[m] == 0) begin
                    m_sel[m] = 2'(tgt);
                end else begin
                    m_showing[m] = 1'b0;
                    m_pending[m] = 2'(tgt);
                    m_left[m]    = p_blank[m];
                end
            end else if (!auto_en || src_update[m_sel[m]]) begin
                m_dwell[m] = 0;
            end else begin
                m_dwell[m] = m_dwell[m] + 1;
            end
        end else begin
            if (next_src) m_pending[m] = 2'((int'(m_pending[m]) + 1) % N);
            m_left[m] = m_left[m] - 1;
            if (m_left[m] == 0) begin
                m_showing[m] = 1'b1;
                m_sel[m]     = m_pending[m];
            end
        end
        e.sel = m_sel[m];
        e.oh  = 4'b0001 << m_sel[m];
    endtask

    // Predictor: one expected output word per instance per active edge.
    initial begin
        exp_t e;
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk);
            model_step(0, e);
            q0.push_back(e);
            model_step(1, e);
            q1.push_back(e);
        end
    end

    task automatic compare(input int m, input exp_t act, input exp_t want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL dut%0d_outputs cycle %0d: got enc=%h dp=%b blank=%b sel=%0d oh=%b, expected enc=%h dp=%b blank=%b sel=%0d oh=%b",
                     m, cycle, act.enc, act.dp, act.blank, act.sel, act.oh,
                     want.enc, want.dp, want.blank, want.sel, want.oh);
        end
    endtask

    // Monitor: pops the scoreboard away from the active edge.
    initial begin
        exp_t want;
        exp_t act;
        forever begin
            @(negedge clk);
            cycle++;
            act = {encoded0, digit_point0, blank0, sel0, sel_onehot0};
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_scoreboard cycle %0d: got empty queue, expected an entry", cycle);
            end else begin
                want = q0.pop_front();
                if (!CPU_RESETN) want = c_RESET_EXP;
                compare(0, act, want);
            end
            act = {encoded1, digit_point1, blank1, sel1, sel_onehot1};
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_scoreboard cycle %0d: got empty queue, expected an entry", cycle);
            end else begin
                want = q1.pop_front();
                if (!CPU_RESETN) want = c_RESET_EXP;
                compare(1, act, want);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
        src_update = '0;
        next_src   = 1'b0;
    endtask

    initial begin
        int rst_hold;
        CPU_RESETN         = 1'b0;
        src_encoded        = '0;
        src_digit_point    = '0;
        src_encoded[0]     = 16'h1234;
        src_digit_point[0] = 4'b0100;
        src_encoded[1]     = 16'h5678;
        src_encoded[2]     = 16'h9abc;
        src_encoded[3]     = 16'hdef0;
        src_update         = '0;
        auto_en            = 1'b0;
        next_src           = 1'b0;
        repeat (3) next_cycle();
        CPU_RESETN = 1'b1;
        repeat (5) next_cycle();

        // Plain auto-rotation through every source and back to 0.
        auto_en = 1'b1;
        repeat (110) next_cycle();

        // Manual advance, including a second press inside the gap.
        auto_en  = 1'b0;
        next_src = 1'b1;
        next_cycle();
        next_src = 1'b1;
        next_cycle();
        repeat (6) next_cycle();

        // Mixed random traffic with occasional asynchronous resets.
        rst_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) CPU_RESETN = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                CPU_RESETN = 1'b0;
                rst_hold   = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 7) == 0) begin
                int s;
                s = $urandom_range(0, 3);
                src_encoded[s]     = 16'($urandom);
                src_digit_point[s] = 4'($urandom);
            end
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 47) == 0) src_update[b] = 1'b1;
            if ($urandom_range(0, 29) == 0) next_src = 1'b1;
            if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
        end

        CPU_RESETN = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
